// File: rtl/madd_ctrl_pkg.sv
// Shared types and helpers for the madd_share_ctrl sequencer:
// the FSM state encoding and the exact multiply-add reference.
package madd_ctrl_pkg;

  localparam int DP_IN_W  = 6;
  localparam int DP_OUT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // op = {c[1:0], b[1:0], a[1:0]}; result a*b+c never exceeds 12
  function automatic logic [DP_OUT_W-1:0] madd_exact(input logic [DP_IN_W-1:0] op);
    logic [DP_OUT_W-1:0] prod;
    prod = {2'b00, op[1:0]} * {2'b00, op[3:2]};
    return prod + {2'b00, op[5:4]};
  endfunction

  function automatic logic [3:0] absdiff4(input logic [3:0] x, input logic [3:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/madd_rr_arb.sv
// Round-robin arbiter: first asserted request at or above ptr, with wrap,
// reported as a one-hot grant plus its index.
module madd_rr_arb #(
  parameter int N_REQ = 2,
  parameter int TAG_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [TAG_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [TAG_W-1:0] idx,
  output logic             any
);

  logic [TAG_W-1:0] cand;
  logic             hit;

  // Scan from ptr upward; the first hit latches and masks later candidates
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand        = TAG_W'((int'(ptr) + k) % N_REQ);
      hit         = !any && req[cand];
      grant[cand] = grant[cand] | hit;
      idx         = hit ? cand : idx;
      any         = any | hit;
    end
  end

endmodule

// File: rtl/madd_share_ctrl.sv
// Time-shares one approximate multiply-add datapath among N_REQ requesters.
// Define MADD_ERR_MON_EN to build the approximation-error monitor counters.
module madd_share_ctrl
  import madd_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ET    = 3,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [DP_IN_W*N_REQ-1:0]   req_op,
  output logic [DP_IN_W-1:0]         dp_in,
  input  logic [DP_OUT_W-1:0]        dp_out,
  input  logic                       cfg_exact,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DP_OUT_W-1:0]        resp_data,
  output logic [$clog2(N_REQ)-1:0]   resp_tag,
  output logic                       busy,
  input  logic                       clr_stats,
  output logic [CNT_W-1:0]           ops_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [CNT_W-1:0]           viol_cnt,
  output logic [3:0]                 err_max
);

  localparam int TAG_W = $clog2(N_REQ);

  state_t             state;
  state_t             next_state;
  logic [N_REQ-1:0]   grant;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_any;
  logic               handshake;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   tag_q;
  logic [DP_IN_W-1:0] grant_op;
  logic [DP_OUT_W-1:0] exact;

  madd_rr_arb #(.N_REQ(N_REQ), .TAG_W(TAG_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign exact = madd_exact(dp_in);
  assign busy  = (state != IDLE);

  always_comb begin
    grant_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_op = grant_op | (req_op[i*DP_IN_W +: DP_IN_W] & {DP_IN_W{grant[i]}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grants are offered only in IDLE; a response blocks the arbiter until taken
  always_comb begin
    next_state = state;
    req_ready  = '0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready  = grant;
          handshake  = 1'b1;
          next_state = EXEC;
        end else begin
          next_state = IDLE;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = RESP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      tag_q      <= '0;
      dp_in      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
    end else begin
      if (handshake) begin
        dp_in  <= grant_op;
        tag_q  <= grant_idx;
        rr_ptr <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      // cfg_exact only matters on the capture edge leaving EXEC
      if (state == EXEC) begin
        resp_data  <= cfg_exact ? exact : dp_out;
        resp_tag   <= tag_q;
        resp_valid <= 1'b1;
      end else if ((state == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifdef MADD_ERR_MON_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [3:0] err_d;

  assign err_d = absdiff4(exact, dp_out);

  // Saturating error statistics; clr_stats overrides a same-cycle update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_cnt  <= '0;
      err_cnt  <= '0;
      viol_cnt <= '0;
      err_max  <= 4'd0;
    end else if (clr_stats) begin
      ops_cnt  <= '0;
      err_cnt  <= '0;
      viol_cnt <= '0;
      err_max  <= 4'd0;
    end else if (state == EXEC) begin
      if (ops_cnt != CNT_MAX) ops_cnt <= ops_cnt + 1'b1;
      if ((err_d != 4'd0) && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
      if ((err_d > 4'(ET)) && (viol_cnt != CNT_MAX)) viol_cnt <= viol_cnt + 1'b1;
      if (err_d > err_max) err_max <= err_d;
    end
  end
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign ops_cnt  = '0;
  assign err_cnt  = '0;
  assign viol_cnt = '0;
  assign err_max  = 4'd0;
`endif

endmodule

// File: tb/tb_madd_share_ctrl.sv
// Directed self-checking bench for madd_share_ctrl with a behavioural datapath
// whose error is injected through err_xor / err_add.
module tb_madd_share_ctrl;
  import madd_ctrl_pkg::*;

  localparam int N_REQ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]  req_ready;
  logic [6*N_REQ-1:0] req_op;
  logic [5:0]        dp_in;
  logic [3:0]        dp_out;
  logic              cfg_exact;
  logic              resp_valid;
  logic              resp_ready;
  logic [3:0]        resp_data;
  logic [0:0]        resp_tag;
  logic              busy;
  logic              clr_stats;
  logic [15:0]       ops_cnt;
  logic [15:0]       err_cnt;
  logic [15:0]       viol_cnt;
  logic [3:0]        err_max;

  logic [3:0] err_xor;
  logic [3:0] err_add;
  int n_checks = 0;
  int n_fail   = 0;

  madd_share_ctrl #(.N_REQ(N_REQ), .ET(3), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .dp_in      (dp_in),
    .dp_out     (dp_out),
    .cfg_exact  (cfg_exact),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy),
    .clr_stats  (clr_stats),
    .ops_cnt    (ops_cnt),
    .err_cnt    (err_cnt),
    .viol_cnt   (viol_cnt),
    .err_max    (err_max)
  );

  // Approximate datapath model: exact result with injectable error
  assign dp_out = (madd_exact(dp_in) ^ err_xor) + err_add;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    clr_stats  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One full transaction from requester r with resp_ready held high
  task automatic run_op(input int r, input logic [5:0] op, input logic [3:0] exp_data,
                        input string tag);
    logic [N_REQ-1:0] oh;
    oh            = '0;
    oh[r]         = 1'b1;
    req_valid     = oh;
    req_op[r*6 +: 6] = op;
    resp_ready    = 1'b1;
    #1;
    check({tag, "_ready"}, req_ready, oh);
    step();
    req_valid = '0;
    check({tag, "_exec_busy"}, busy, 1);
    check({tag, "_exec_nvalid"}, resp_valid, 0);
    check({tag, "_dp_in"}, dp_in, op);
    step();
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_tag"}, resp_tag, r);
    step();
    check({tag, "_done"}, resp_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int adds [4];
    adds = '{0, 2, 4, 1};
    rst = 1'b1; req_valid = '0; req_op = '0; cfg_exact = 1'b0;
    resp_ready = 1'b0; clr_stats = 1'b0; err_xor = 4'd0; err_add = 4'd0;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_tag", resp_tag, 0);
    check("rst_dp_in", dp_in, 0);
    check("rst_ready", req_ready, 0);
    check("rst_ops", ops_cnt, 0);

    // 1: single op, 3*3+2 = 11
    run_op(0, 6'b10_11_11, 4'd11, "single");

    // 2: fairness with both requesters held valid
    do_reset();
    req_op     = {6'b11_10_01, 6'b01_01_11};
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fair_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      check("fair_exec", resp_valid, 0);
      step();
      check("fair_valid", resp_valid, 1);
      check("fair_tag", resp_tag, i % 2);
      check("fair_data", resp_data, (i % 2 == 0) ? 4 : 5);
      step();
      check("fair_gap", resp_valid, 0);
    end

    // 3: backpressure; rr_ptr is back at 0
    resp_ready = 1'b0;
    #1;
    check("bp_grant", req_ready, 2'b01);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", resp_valid, 1);
      check("bp_data", resp_data, 4);
      check("bp_tag", resp_tag, 0);
      check("bp_noready", req_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_hold", resp_data, 4);
    step();
    check("bp_idle", busy, 0);
    check("bp_released", resp_valid, 0);
    check("bp_next_grant", req_ready, 2'b10);
    req_valid = '0;
    #1;
    check("withdraw_ready", req_ready, 0);
    step();
    check("withdraw_idle", busy, 0);

    // 4: exact vs approximate result, approx = 5 ^ 4
    err_xor   = 4'b0100;
    cfg_exact = 1'b1;
    run_op(0, 6'b01_10_10, 4'd5, "exact");
    cfg_exact = 1'b0;
    run_op(0, 6'b01_10_10, 4'd1, "approx");
    err_xor = 4'd0;

    // 5: monitor, errors 0,2,4,1 against exact 1
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    check("mon_clr0_ops", ops_cnt, 0);
    check("mon_clr0_max", err_max, 0);
    for (int i = 0; i < 4; i++) begin
      err_add = 4'(adds[i]);
      run_op(i % 2, 6'b00_01_01, 4'(1 + adds[i]), "mon");
    end
    err_add = 4'd0;
`ifdef MADD_ERR_MON_EN
    check("mon_ops", ops_cnt, 4);
    check("mon_err", err_cnt, 3);
    check("mon_viol", viol_cnt, 1);
    check("mon_max", err_max, 4);
`else
    check("mon_ops", ops_cnt, 0);
    check("mon_err", err_cnt, 0);
    check("mon_viol", viol_cnt, 0);
    check("mon_max", err_max, 0);
`endif
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    check("mon_clr_ops", ops_cnt, 0);
    check("mon_clr_err", err_cnt, 0);
    check("mon_clr_viol", viol_cnt, 0);
    check("mon_clr_max", err_max, 0);

    // 6: reset during EXEC aborts the op
    req_op[5:0] = 6'b11_11_11;
    req_valid   = 2'b01;
    resp_ready  = 1'b1;
    step();
    req_valid = '0;
    check("abort_exec", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", resp_valid, 0);
    check("abort_dp_in", dp_in, 0);
    check("abort_data", resp_data, 0);
    check("abort_tag", resp_tag, 0);
    step();
    step();
    check("abort_noresp", resp_valid, 0);
    rst = 1'b0;
    run_op(1, 6'b11_11_11, 4'd12, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
